// File: rtl/fifo_burst_pkg.sv
// -----------------------------------------------------------------------------
// fifo_burst_pkg
// Shared types and constants for the FIFO read-side burst write controller.
//   state_e    : sequencer states (IDLE, CMD, DATA, DRAIN)
//   LEN_W      : width of a burst length in beats (1..256 needs 9 bits)
//   CMD_LEN_W  : width of the cmd_len field (beats minus one)
//   step_bytes : byte stride between consecutive bursts
// -----------------------------------------------------------------------------
package fifo_burst_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        DATA  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    localparam int LEN_W     = 9;
    localparam int CMD_LEN_W = 8;

    // Address advance per burst; a shortened final burst still advances by a full step.
    function automatic int step_bytes(input int burst_len, input int data_width);
        return burst_len * data_width / 8;
    endfunction

endpackage

// File: rtl/fifo_burst_wr_ctrl_if.sv
// -----------------------------------------------------------------------------
// fifo_burst_wr_ctrl_if
// Bundles the FIFO read port, the DDR burst command channel and the DDR write
// data channel seen by the burst write controller.
//   master : the controller (drives fifo_rd_en, cmd_*, wdata*)
//   slave  : FIFO + DDR front end (drives level/empty/data and the readies)
// -----------------------------------------------------------------------------
interface fifo_burst_wr_ctrl_if #(
    parameter int RD_DEPTH_WIDTH = 10,
    parameter int DATA_WIDTH     = 256,
    parameter int ADDR_WIDTH     = 28
);
    import fifo_burst_pkg::*;

    // FIFO read side
    logic [RD_DEPTH_WIDTH:0] fifo_rd_water_level;
    logic                    fifo_rd_empty;
    logic                    fifo_rd_en;
    logic [DATA_WIDTH-1:0]   fifo_rd_data;
    // Burst command channel
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [ADDR_WIDTH-1:0]   cmd_addr;
    logic [CMD_LEN_W-1:0]    cmd_len;
    // Write data channel
    logic                    wdata_valid;
    logic                    wdata_ready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic                    wdata_last;

    modport master (
        input  fifo_rd_water_level, fifo_rd_empty, fifo_rd_data, cmd_ready, wdata_ready,
        output fifo_rd_en, cmd_valid, cmd_addr, cmd_len, wdata_valid, wdata, wdata_last
    );

    modport slave (
        output fifo_rd_water_level, fifo_rd_empty, fifo_rd_data, cmd_ready, wdata_ready,
        input  fifo_rd_en, cmd_valid, cmd_addr, cmd_len, wdata_valid, wdata, wdata_last
    );

endinterface

// File: rtl/burst_skid_buf.sv
// -----------------------------------------------------------------------------
// burst_skid_buf
// Two-entry FIFO that absorbs the one-cycle FIFO read latency while the write
// channel applies backpressure.
//   clk, rst     : clock, asynchronous active-high reset
//   push_i       : write push_data_i (caller guarantees not full)
//   pop_i        : drop the head entry (caller guarantees not empty)
//   head_o       : oldest entry
//   count_o      : occupancy 0..2
// -----------------------------------------------------------------------------
module burst_skid_buf #(
    parameter int DATA_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] head_o,
    output logic [1:0]            count_o
);

    logic [DATA_WIDTH-1:0] mem_q [2];
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [1:0]            count_q;

    // NOTE: the data storage has no reset; only pointers and count do. Stale
    // contents are never observed because count_q gates every read.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) wr_ptr_q <= ~wr_ptr_q;
            if (pop_i)  rd_ptr_q <= ~rd_ptr_q;
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fifo_burst_wr_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_burst_wr_ctrl
// Read-side sequencer of the width-converter FIFO: waits for enough beats,
// issues a fixed-length DDR write burst command, pops the burst's beats and
// forwards them with valid/ready/last, stepping a frame address pointer.
//   clk, rst    : FIFO read clock, asynchronous active-high reset
//   frame_start : pulse, arm a new frame at BASE_ADDR (deferred mid-burst)
//   bus         : fifo_burst_wr_ctrl_if.master (FIFO read, cmd, wdata)
//   frame_done  : one-cycle pulse after the frame's last beat is accepted
//   busy        : frame armed or burst in flight
// Build option: FIFO_BURST_AUTO_RESTART_EN re-arms the frame automatically
// when it completes (continuous ring buffer).
// -----------------------------------------------------------------------------
module fifo_burst_wr_ctrl
    import fifo_burst_pkg::*;
#(
    parameter int                    RD_DEPTH_WIDTH = 10,
    parameter int                    DATA_WIDTH     = 256,
    parameter int                    ADDR_WIDTH     = 28,
    parameter int                    BURST_LEN      = 16,
    parameter int                    FRAME_BEATS    = 57600,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                frame_start,
    fifo_burst_wr_ctrl_if.master bus,
    output logic                frame_done,
    output logic                busy
);

    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(step_bytes(BURST_LEN, DATA_WIDTH));

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] addr_ptr_q;
    logic [31:0]           remaining_q;
    logic                  frame_active_q;
    logic                  pending_q;
    logic [LEN_W-1:0]      len_q;
    logic [LEN_W-1:0]      issued_q;
    logic [LEN_W-1:0]      accepted_q;
    logic                  inflight_q;
    logic                  cmd_valid_q;
    logic [ADDR_WIDTH-1:0] cmd_addr_q;
    logic [CMD_LEN_W-1:0]  cmd_len_q;
    logic                  frame_done_q;

    logic [LEN_W-1:0]      this_len;
    logic [31:0]           rem_after;
    logic                  level_ok;
    logic                  rd_en;
    logic                  wvalid;
    logic                  wlast;
    logic                  accept;
    logic [1:0]            skid_count;
    logic [DATA_WIDTH-1:0] skid_head;

    // NOTE: every combinational output is given a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        this_len = LEN_W'(BURST_LEN);
        if (remaining_q < 32'(BURST_LEN)) begin
            this_len = remaining_q[LEN_W-1:0];
        end
    end

    assign rem_after = remaining_q - 32'(len_q);
    assign level_ok  = 32'(bus.fifo_rd_water_level) >= 32'(this_len);

    // At most two beats may be owned at once (buffered + in flight), so a
    // pop is always guaranteed a skid slot even if wdata_ready stays low.
    assign rd_en  = (state_q == DATA) && (issued_q < len_q) && !bus.fifo_rd_empty &&
                    ((skid_count + {1'b0, inflight_q}) < 2'd2);
    assign wvalid = (skid_count != 2'd0);
    assign wlast  = wvalid && (accepted_q == len_q - LEN_W'(1));
    assign accept = wvalid && bus.wdata_ready;

    burst_skid_buf #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
        .clk        (clk),
        .rst        (rst),
        .push_i     (inflight_q),
        .push_data_i(bus.fifo_rd_data),
        .pop_i      (accept),
        .head_o     (skid_head),
        .count_o    (skid_count)
    );

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples pre-edge values; later assignments in this block
    // intentionally override earlier defaults.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            addr_ptr_q     <= BASE_ADDR;
            remaining_q    <= '0;
            frame_active_q <= 1'b0;
            pending_q      <= 1'b0;
            len_q          <= '0;
            issued_q       <= '0;
            accepted_q     <= '0;
            inflight_q     <= 1'b0;
            cmd_valid_q    <= 1'b0;
            cmd_addr_q     <= '0;
            cmd_len_q      <= '0;
            frame_done_q   <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            inflight_q   <= rd_en;
            if (rd_en)  issued_q   <= issued_q + LEN_W'(1);
            if (accept) accepted_q <= accepted_q + LEN_W'(1);
            if (frame_start && state_q != IDLE) pending_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    if (frame_start) begin
                        addr_ptr_q     <= BASE_ADDR;
                        remaining_q    <= 32'(FRAME_BEATS);
                        frame_active_q <= 1'b1;
                    end else if (frame_active_q && remaining_q != 32'd0 && level_ok) begin
                        state_q     <= CMD;
                        cmd_valid_q <= 1'b1;
                        cmd_addr_q  <= addr_ptr_q;
                        cmd_len_q   <= CMD_LEN_W'(this_len - LEN_W'(1));
                        len_q       <= this_len;
                        issued_q    <= '0;
                        accepted_q  <= '0;
                    end
                end
                CMD: begin
                    if (bus.cmd_ready) begin
                        cmd_valid_q <= 1'b0;
                        state_q     <= DATA;
                    end
                end
                DATA: begin
                    if (rd_en && (issued_q + LEN_W'(1) == len_q)) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (accept && wlast) begin
                        state_q     <= IDLE;
                        addr_ptr_q  <= addr_ptr_q + STEP;
                        remaining_q <= rem_after;
                        if (rem_after == 32'd0) begin
                            frame_done_q <= 1'b1;
`ifdef FIFO_BURST_AUTO_RESTART_EN
                            addr_ptr_q  <= BASE_ADDR;
                            remaining_q <= 32'(FRAME_BEATS);
`else
                            frame_active_q <= 1'b0;
`endif
                        end
                        // A deferred (or coincident) frame_start wins over the
                        // normal advance once the burst has fully drained.
                        if (frame_start || pending_q) begin
                            addr_ptr_q     <= BASE_ADDR;
                            remaining_q    <= 32'(FRAME_BEATS);
                            frame_active_q <= 1'b1;
                            pending_q      <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.fifo_rd_en  = rd_en;
    assign bus.cmd_valid   = cmd_valid_q;
    assign bus.cmd_addr    = cmd_addr_q;
    assign bus.cmd_len     = cmd_len_q;
    assign bus.wdata_valid = wvalid;
    assign bus.wdata       = wvalid ? skid_head : '0;
    assign bus.wdata_last  = wlast;
    assign frame_done      = frame_done_q;
    assign busy            = frame_active_q | (state_q != IDLE);

endmodule

// File: tb/tb_fifo_burst_wr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_burst_wr_ctrl
// Directed bench for fifo_burst_wr_ctrl with FRAME_BEATS=36 (bursts of 16, 16
// and a shortened 4), a FIFO model that returns beat index i in every 32-bit
// lane, and a monitor that scores data order, wdata_last position and
// command addresses/lengths.
// -----------------------------------------------------------------------------
module tb_fifo_burst_wr_ctrl;
    import fifo_burst_pkg::*;

    localparam int RDW = 10;
    localparam int DW  = 256;
    localparam int AW  = 28;

    logic clk = 1'b0;
    logic rst;
    logic frame_start;
    logic frame_done;
    logic busy;
    logic bp_en;

    always #5 clk = ~clk;

    fifo_burst_wr_ctrl_if #(.RD_DEPTH_WIDTH(RDW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    fifo_burst_wr_ctrl #(
        .RD_DEPTH_WIDTH(RDW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .BURST_LEN(16), .FRAME_BEATS(36), .BASE_ADDR('0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_start(frame_start),
        .bus        (bus.master),
        .frame_done (frame_done),
        .busy       (busy)
    );

    // ---------------- FIFO model ----------------
    int unsigned added_total  = 0;   // written by the main sequence only
    int unsigned popped_total = 0;   // written by the FIFO model only

    assign bus.fifo_rd_water_level = 11'(added_total - popped_total);
    assign bus.fifo_rd_empty       = (added_total == popped_total);

    always @(posedge clk) begin
        if (bus.fifo_rd_en) begin
            bus.fifo_rd_data <= {8{popped_total}};
            popped_total     <= popped_total + 1;
        end
    end

    // Write-channel ready: always 1, or a coin toss per cycle when bp_en.
    always @(posedge clk) begin
        #2;
        bus.wdata_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // ---------------- Monitor ----------------
    int unsigned exp_idx = 0;
    int rd_en_cnt = 0, cmd_cnt = 0, beats = 0, data_err = 0, last_err = 0;
    int last_cnt = 0, fd_cnt = 0, skid_err = 0, beat_in_burst = 0, cur_len = 0;
    logic [AW-1:0] cmd_addr_log [16];
    logic [7:0]    cmd_len_log  [16];

    always @(negedge clk) begin
        if (rst) begin
            exp_idx       = popped_total;
            beat_in_burst = 0;
        end else begin
            if (bus.fifo_rd_en) rd_en_cnt++;
            if (bus.cmd_valid && bus.cmd_ready) begin
                if (cmd_cnt < 16) begin
                    cmd_addr_log[cmd_cnt] = bus.cmd_addr;
                    cmd_len_log[cmd_cnt]  = bus.cmd_len;
                end
                cur_len = int'(bus.cmd_len);
                cmd_cnt++;
            end
            if (bus.wdata_valid && bus.wdata_ready) begin
                if (bus.wdata !== {8{exp_idx}}) data_err++;
                exp_idx++;
                if (bus.wdata_last !== (beat_in_burst == cur_len)) last_err++;
                if (bus.wdata_last) begin
                    last_cnt++;
                    beat_in_burst = 0;
                end else begin
                    beat_in_burst++;
                end
                beats++;
            end
            if (frame_done) fd_cnt++;
            if (dut.u_skid.count_o > 2'd2) skid_err++;
        end
    end

    // ---------------- Checking ----------------
    int total  = 0;
    int passed = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    typedef struct {
        int          level;
        bit          ready;
        bit          exp_valid;
        logic [27:0] exp_addr;
        logic [7:0]  exp_len;
    } gate_vec_t;

    typedef struct {
        logic [27:0] addr;
        logic [7:0]  len;
    } cmd_vec_t;

    gate_vec_t gate_tbl [5];
    cmd_vec_t  cmd_tbl  [3];

    initial begin
        gate_tbl[0] = '{level: 0,  ready: 1'b0, exp_valid: 1'b0, exp_addr: 28'h0, exp_len: 8'd0};
        gate_tbl[1] = '{level: 8,  ready: 1'b0, exp_valid: 1'b0, exp_addr: 28'h0, exp_len: 8'd0};
        gate_tbl[2] = '{level: 15, ready: 1'b0, exp_valid: 1'b0, exp_addr: 28'h0, exp_len: 8'd0};
        gate_tbl[3] = '{level: 16, ready: 1'b0, exp_valid: 1'b1, exp_addr: 28'h0, exp_len: 8'd15};
        gate_tbl[4] = '{level: 16, ready: 1'b0, exp_valid: 1'b1, exp_addr: 28'h0, exp_len: 8'd15};
        cmd_tbl[0]  = '{addr: 28'h000, len: 8'd15};
        cmd_tbl[1]  = '{addr: 28'h200, len: 8'd15};
        cmd_tbl[2]  = '{addr: 28'h400, len: 8'd3};

        rst = 1'b1; frame_start = 1'b0; bus.cmd_ready = 1'b0; bp_en = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_cmd_valid",   64'(bus.cmd_valid),   64'd0);
        check("rst_fifo_rd_en",  64'(bus.fifo_rd_en),  64'd0);
        check("rst_wdata_valid", 64'(bus.wdata_valid), 64'd0);
        check("rst_wdata_last",  64'(bus.wdata_last),  64'd0);
        check("rst_wdata_zero",  64'(bus.wdata == '0), 64'd1);
        check("rst_cmd_addr",    64'(bus.cmd_addr),    64'd0);
        check("rst_cmd_len",     64'(bus.cmd_len),     64'd0);
        check("rst_frame_done",  64'(frame_done),      64'd0);
        check("rst_busy",        64'(busy),            64'd0);

        rst = 1'b0;
        tick();
        pulse_start();
        tick();
        check("armed_busy", 64'(busy), 64'd1);

        // Water-level gating with cmd_ready held low
        foreach (gate_tbl[i]) begin
            added_total   = gate_tbl[i].level;
            bus.cmd_ready = gate_tbl[i].ready;
            repeat (4) tick();
            check($sformatf("gate%0d_cmd_valid", i), 64'(bus.cmd_valid), 64'(gate_tbl[i].exp_valid));
            if (gate_tbl[i].exp_valid) begin
                check($sformatf("gate%0d_cmd_addr", i), 64'(bus.cmd_addr), 64'(gate_tbl[i].exp_addr));
                check($sformatf("gate%0d_cmd_len", i),  64'(bus.cmd_len),  64'(gate_tbl[i].exp_len));
            end
            check($sformatf("gate%0d_no_pop", i), 64'(rd_en_cnt), 64'd0);
        end

        // First burst, ready always 1
        bus.cmd_ready = 1'b1;
        for (int i = 0; i < 200 && beats < 16; i++) tick();
        check("burst1_beats", 64'(beats), 64'd16);
        repeat (5) tick();
        check("burst1_rd_en_pulses", 64'(rd_en_cnt), 64'd16);
        check("burst1_cmd_count",    64'(cmd_cnt),   64'd1);
        check("burst1_last_count",   64'(last_cnt),  64'd1);
        check("burst1_no_done",      64'(fd_cnt),    64'd0);
        check("burst1_busy",         64'(busy),      64'd1);

        // Rest of the frame (full burst + shortened burst) under backpressure
        bp_en = 1'b1;
        added_total = added_total + 20;
        for (int i = 0; i < 2000 && fd_cnt < 1; i++) tick();
        check("frame1_done", 64'(fd_cnt), 64'd1);
        foreach (cmd_tbl[i]) begin
            check($sformatf("frame1_cmd%0d_addr", i), 64'(cmd_addr_log[i]), 64'(cmd_tbl[i].addr));
            check($sformatf("frame1_cmd%0d_len", i),  64'(cmd_len_log[i]),  64'(cmd_tbl[i].len));
        end
        check("frame1_beats",     64'(beats),    64'd36);
        check("frame1_data_err",  64'(data_err), 64'd0);
        check("frame1_last_err",  64'(last_err), 64'd0);
        check("frame1_last_cnt",  64'(last_cnt), 64'd3);
        check("frame1_skid_err",  64'(skid_err), 64'd0);
        repeat (4) tick();
        check("frame1_done_width", 64'(fd_cnt), 64'd1);
`ifdef FIFO_BURST_AUTO_RESTART_EN
        check("frame1_busy_after", 64'(busy), 64'd1);
`else
        check("frame1_busy_after", 64'(busy), 64'd0);
`endif

        // frame_start while a burst is in DATA: burst completes, then restart at base
        pulse_start();
        added_total = added_total + 60;
        for (int i = 0; i < 500 && rd_en_cnt < 40; i++) tick();
        check("mid_state_data", 64'(dut.state_q), 64'(DATA));
        pulse_start();
        for (int i = 0; i < 1000 && cmd_cnt < 5; i++) tick();
        check("mid_cmd4_count", 64'(cmd_cnt), 64'd5);
        check("mid_cmd4_addr",  64'(cmd_addr_log[4]), 64'h000);
        check("mid_cmd4_len",   64'(cmd_len_log[4]),  64'd15);
        for (int i = 0; i < 1000 && cmd_cnt < 6; i++) tick();
        check("mid_cmd5_addr",  64'(cmd_addr_log[5]), 64'h200);
        check("mid_data_err",   64'(data_err), 64'd0);

        // Reset in the middle of a burst
        for (int i = 0; i < 500 && rd_en_cnt < 71; i++) tick();
        check("rstmid_state_data", 64'(dut.state_q), 64'(DATA));
        rst = 1'b1;
        tick();
        check("rstmid_cmd_valid",   64'(bus.cmd_valid),   64'd0);
        check("rstmid_fifo_rd_en",  64'(bus.fifo_rd_en),  64'd0);
        check("rstmid_wdata_valid", 64'(bus.wdata_valid), 64'd0);
        check("rstmid_wdata_last",  64'(bus.wdata_last),  64'd0);
        check("rstmid_frame_done",  64'(frame_done),      64'd0);
        check("rstmid_busy",        64'(busy),            64'd0);
        check("rstmid_state_idle",  64'(dut.state_q),     64'(IDLE));
        check("rstmid_skid_empty",  64'(dut.u_skid.count_o), 64'd0);
        tick();
        rst = 1'b0;
        added_total = popped_total;   // FIFO shares the reset
        tick();

        // Clean frame after reset
        pulse_start();
        added_total = added_total + 36;
        for (int i = 0; i < 3000 && fd_cnt < 2; i++) tick();
        check("frame3_done", 64'(fd_cnt), 64'd2);
        foreach (cmd_tbl[i]) begin
            check($sformatf("frame3_cmd%0d_addr", i), 64'(cmd_addr_log[6 + i]), 64'(cmd_tbl[i].addr));
            check($sformatf("frame3_cmd%0d_len", i),  64'(cmd_len_log[6 + i]),  64'(cmd_tbl[i].len));
        end
        check("frame3_data_err", 64'(data_err), 64'd0);
        check("frame3_last_err", 64'(last_err), 64'd0);
        check("frame3_skid_err", 64'(skid_err), 64'd0);
        repeat (4) tick();
`ifdef FIFO_BURST_AUTO_RESTART_EN
        check("auto_busy_stays", 64'(busy), 64'd1);
        added_total = added_total + 16;
        for (int i = 0; i < 1000 && cmd_cnt < 10; i++) tick();
        check("auto_cmd_count", 64'(cmd_cnt), 64'd10);
        check("auto_cmd_addr",  64'(cmd_addr_log[9]), 64'h000);
`else
        check("frame3_busy_after", 64'(busy), 64'd0);
        check("frame3_cmd_total",  64'(cmd_cnt), 64'd9);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fifo_burst_wr_ctrl.md
Name: fifo_burst_wr_ctrl

Overview:
- Read-side sequencer for the 16-in/256-out async width-converter FIFO.
- Watches the FIFO read water level and issues fixed-length write-burst commands (address + length) to the DDR write port.
- Pops the burst's beats from the FIFO and forwards them with valid/ready and last, advancing a frame address pointer.
- Sits between the FIFO read side and the DDR write-channel front end, in the FIFO read clock domain.

Parameters:
- RD_DEPTH_WIDTH, 10, FIFO read depth width (water level is RD_DEPTH_WIDTH+1 bits)
- DATA_WIDTH, 256, FIFO read / DDR beat width
- ADDR_WIDTH, 28, byte address width
- BURST_LEN, 16, beats per full burst (1..256)
- FRAME_BEATS, 57600, 256-bit beats per frame (1280x720x16bpp)
- BASE_ADDR, 0, frame byte base address

Ports:
- clk  in  1  FIFO read clock; sole clock
- rst  in  1  asynchronous, active-high reset
- frame_start  in  1  pulse: arm a new frame at BASE_ADDR
- fifo_rd_water_level  in  RD_DEPTH_WIDTH+1  FIFO read-side fill
- fifo_rd_empty  in  1  FIFO empty
- fifo_rd_en  out  1  FIFO pop
- fifo_rd_data  in  DATA_WIDTH  FIFO data; valid one cycle after fifo_rd_en
- cmd_valid  out  1  burst command valid
- cmd_ready  in  1  burst command accepted
- cmd_addr  out  ADDR_WIDTH  burst byte address
- cmd_len  out  8  beats minus one
- wdata_valid  out  1  write beat valid
- wdata_ready  in  1  write beat accepted
- wdata  out  DATA_WIDTH  write beat
- wdata_last  out  1  final beat of burst
- frame_done  out  1  one-cycle pulse after last beat of frame accepted
- busy  out  1  frame armed or burst in flight

Behaviour:
- Reset: all outputs 0. State IDLE, addr_ptr=BASE_ADDR, remaining=0, frame_active=0, skid buffer empty.
- Step size: STEP = BURST_LEN*DATA_WIDTH/8 bytes (512 default). addr_ptr wraps modulo 2^ADDR_WIDTH.
- this_len = min(BURST_LEN, remaining).
- States:
  - IDLE: if frame_active and remaining>0 and fifo_rd_water_level >= this_len, go to CMD next cycle.
  - CMD: cmd_valid=1, with cmd_addr=addr_ptr and cmd_len=this_len-1, all held stable until cmd_ready. On the handshake, go to DATA.
  - DATA: fifo_rd_en=1 when issued<this_len, !fifo_rd_empty, and skid_count + inflight < 2.
    - inflight is the rd_en of the previous cycle; data is captured into the skid buffer one cycle after rd_en.
    - When issued reaches this_len, go to DRAIN.
  - DRAIN: wait until the beat with wdata_last is accepted (wdata_valid & wdata_ready). Then addr_ptr += STEP, remaining -= this_len, and go to IDLE.
    - If remaining becomes 0: frame_done pulses that cycle and frame_active clears.
- Data path:
  - wdata_valid = skid_count != 0; wdata is the skid head.
  - wdata_last is asserted on the beat whose accepted-beat count equals this_len-1.
  - wdata_ready may drop at any cycle; no beat is lost or duplicated.
- frame_start:
  - In IDLE with no burst pending: load addr_ptr=BASE_ADDR, remaining=FRAME_BEATS, frame_active=1.
  - While in CMD/DATA/DRAIN: latch as pending and apply on the next IDLE entry. The current burst always completes.
- Final burst of a frame: shortened to the remaining beats (57600 mod 16 = 0 by default; partial bursts must still be correct).
- cmd_ready asserted in the same cycle cmd_valid rises is accepted (zero-wait handshake).
- busy = frame_active | (state != IDLE).
- rst mid-burst: immediate return to reset state. A partially read FIFO is the system's responsibility; the FIFO is reset from the same rst.

Optional Feature:
- Macro: FIFO_BURST_AUTO_RESTART_EN.
- Defined: when the last beat of a frame is accepted, frame_done pulses and the frame re-arms in the same cycle (addr_ptr=BASE_ADDR, remaining=FRAME_BEATS). frame_active stays 1 (continuous ring buffer), and frame_start is still honoured as a resync.
- Undefined: frame_active clears at frame end, and a new frame_start is required.

Decomposition:
- Shared package fifo_burst_pkg holds:
  - state enum (IDLE, CMD, DATA, DRAIN)
  - STEP and this_len width constants
  - cmd_len width (8)
- One sub-module, burst_skid_buf: 2-entry DATA_WIDTH FIFO with push/pop/count. It absorbs the 1-cycle FIFO read latency under wdata_ready backpressure.

Test Plan:
- Level gating: FRAME_BEATS=32, BURST_LEN=16, water level held at 15 -> no cmd_valid. Level set to 16 -> cmd_valid with cmd_addr=0x0, cmd_len=15; exactly 16 fifo_rd_en pulses.
- Command sequence: two bursts, ready always 1 -> second cmd_addr=0x200; 16 beats with wdata_last on the 16th; frame_done pulses once after beat 32.
- Backpressure: wdata_ready random 50% -> wdata sequence equals the FIFO pop order, no loss or duplication; skid_count never exceeds 2.
- Partial burst: FRAME_BEATS=20 -> bursts of cmd_len=15 then cmd_len=3 at 0x200; wdata_last on beat 4 of the second burst.
- Mid-burst events: frame_start mid-DATA -> burst completes, next cmd_addr=BASE_ADDR. rst asserted mid-DATA -> all outputs 0 next edge; state IDLE.
- Auto restart (with FIFO_BURST_AUTO_RESTART_EN): after frame_done, next cmd_addr=BASE_ADDR without frame_start, and busy stays 1.
